ldpc_3gpp_enc_src_buf_ctrl: RTL and testbench

Write-side controller for the encoder's ping-pong source RAM, sitting directly upstream of the encoder read address generator. It accepts framed source words from the input interface and writes them to one of two RAM buffers. It hands filled buffers to the encoder engine, which drives the read address generator's clear/enable. It also applies backpressure when both buffers are owned by the engine.

---
 rtl/ldpc_3gpp_enc_src_buf_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ldpc_3gpp_enc_src_buf_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_3gpp_enc_src_buf_ctrl.sv
`default_nettype none
//============================================================================
// Module   : ldpc_3gpp_enc_src_buf_ctrl
// Brief    : Write-side controller of the LDPC encoder ping-pong source RAM.
//            Frames incoming source words into one of two buffers, hands
//            completed buffers to the encoder engine and applies
//            backpressure while the engine owns both buffers.
// Revision : 1.0 - initial release
//============================================================================
module ldpc_3gpp_enc_src_buf_ctrl #(
  parameter int pDAT_W  = 8,
  parameter int pADDR_W = 8
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  // source word interface
  input  logic [pADDR_W-1:0] ilen_m1,
  input  logic               isop,
  input  logic               ieop,
  input  logic               ival,
  input  logic [pDAT_W-1:0]  idat,
  output logic               ordy,
  // RAM write port
  output logic               owrite,
  output logic               owbuf,
  output logic [pADDR_W-1:0] owaddr,
  output logic [pDAT_W-1:0]  owdat,
  // engine / read side handshake
  input  logic               irdone,
  output logic               orbuf,
  output logic               ofull,
  output logic               ostart,
  output logic               oerr
);

  localparam logic [1:0] c_USED_MAX = 2'd2;

  //--------------------------------------------------------------------------
  // state registers
  //--------------------------------------------------------------------------
  logic               r_wbuf;      // buffer currently being filled
  logic               r_rbuf;      // buffer presented to the engine
  logic [1:0]         r_used_cnt;  // number of filled buffers owned by engine
  logic               r_in_frame;
  logic [pADDR_W-1:0] r_wcnt;
  logic [pADDR_W-1:0] r_len_m1;

  // registered write port and pulses
  logic               r_write;
  logic               r_write_buf;
  logic [pADDR_W-1:0] r_write_addr;
  logic [pDAT_W-1:0]  r_write_dat;
  logic               r_start;
  logic               r_err;

  //--------------------------------------------------------------------------
  // combinational decode of the current input word
  //--------------------------------------------------------------------------
  logic               w_rdy;
  logic               w_accept;
  logic               w_wr;
  logic [pADDR_W-1:0] w_addr;
  logic [pADDR_W-1:0] w_len_m1;
  logic               w_at_len;
  logic               w_last;
  logic               w_err;
  logic               w_rd;
  logic [1:0]         w_used_nxt;

  assign w_rdy    = (r_used_cnt != c_USED_MAX);
  assign w_accept = ival & w_rdy & iclkena;

  // A word is written if it opens a block or lands inside one; strays drop.
  assign w_wr     = w_accept & (isop | r_in_frame);

  // An isop always restarts at address 0 and uses the freshly offered length.
  assign w_addr   = isop ? '0 : r_wcnt;
  assign w_len_m1 = isop ? ilen_m1 : r_len_m1;
  assign w_at_len = (w_addr == w_len_m1);

  // Block ends at the programmed length or on an early ieop.
  assign w_last   = w_wr & (w_at_len | ieop);
  assign w_err    = w_wr & ieop & ~w_at_len;

  // Engine release is only honoured while it actually owns a buffer.
  assign w_rd     = iclkena & irdone & (r_used_cnt != 2'd0);

  // Buffer occupancy: completion and release in the same cycle cancel out.
  always_comb begin
    w_used_nxt = r_used_cnt;
    case ({w_last, w_rd})
      2'b10:   w_used_nxt = r_used_cnt + 2'd1;
      2'b01:   w_used_nxt = r_used_cnt - 2'd1;
      default: w_used_nxt = r_used_cnt;
    endcase
  end

  //--------------------------------------------------------------------------
  // Framing state: in_frame, word counter, latched length and write buffer.
  //--------------------------------------------------------------------------
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_in_frame <= 1'b0;
      r_wcnt     <= '0;
      r_len_m1   <= '0;
      r_wbuf     <= 1'b0;
    end else if (iclkena) begin
      if (w_accept && isop) begin
        r_len_m1 <= ilen_m1;
      end
      if (w_wr) begin
        r_in_frame <= ~w_last;
        r_wcnt     <= w_last ? '0 : (w_addr + pADDR_W'(1));
      end
      if (w_last) begin
        r_wbuf <= ~r_wbuf;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Ownership tracking between the write side and the engine.
  //--------------------------------------------------------------------------
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_used_cnt <= 2'd0;
      r_rbuf     <= 1'b0;
    end else if (iclkena) begin
      r_used_cnt <= w_used_nxt;
      if (w_rd) begin
        r_rbuf <= ~r_rbuf;
      end
    end
  end

  //--------------------------------------------------------------------------
  // One-cycle registered RAM write port with completion/error pulses.
  //--------------------------------------------------------------------------
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_write      <= 1'b0;
      r_write_buf  <= 1'b0;
      r_write_addr <= '0;
      r_write_dat  <= '0;
      r_start      <= 1'b0;
      r_err        <= 1'b0;
    end else if (iclkena) begin
      r_write <= w_wr;
      r_start <= w_last;
      r_err   <= w_err;
      if (w_wr) begin
        r_write_buf  <= r_wbuf;
        r_write_addr <= w_addr;
        r_write_dat  <= idat;
      end
    end
  end

  //--------------------------------------------------------------------------
  // outputs
  //--------------------------------------------------------------------------
  assign ordy   = w_rdy;
  assign owrite = r_write;
  assign owbuf  = r_write_buf;
  assign owaddr = r_write_addr;
  assign owdat  = r_write_dat;
  assign orbuf  = r_rbuf;
  assign ofull  = (r_used_cnt != 2'd0);
  assign ostart = r_start;
  assign oerr   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_3gpp_enc_src_buf_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_ldpc_3gpp_enc_src_buf_ctrl
// Brief    : Scoreboard bench for the source buffer write controller. The
//            stimulus side pushes hand-computed RAM writes into a queue; a
//            monitor pops and compares whenever the DUT presents a write.
// Revision : 1.0 - initial release
//============================================================================
module tb_ldpc_3gpp_enc_src_buf_ctrl;

  logic       iclk = 1'b0;
  logic       ireset = 1'b1;
  logic       iclkena = 1'b1;
  logic [7:0] ilen_m1 = '0;
  logic       isop = 1'b0;
  logic       ieop = 1'b0;
  logic       ival = 1'b0;
  logic [7:0] idat = '0;
  logic       ordy;
  logic       owrite;
  logic       owbuf;
  logic [7:0] owaddr;
  logic [7:0] owdat;
  logic       irdone = 1'b0;
  logic       orbuf;
  logic       ofull;
  logic       ostart;
  logic       oerr;

  typedef struct packed {
    logic       wbuf;
    logic [7:0] addr;
    logic [7:0] dat;
    logic       start;
    logic       err;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  logic r_edge_live = 1'b0;

  ldpc_3gpp_enc_src_buf_ctrl #(.pDAT_W(8), .pADDR_W(8)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .ilen_m1(ilen_m1), .isop(isop), .ieop(ieop), .ival(ival), .idat(idat),
    .ordy(ordy), .owrite(owrite), .owbuf(owbuf), .owaddr(owaddr),
    .owdat(owdat), .irdone(irdone), .orbuf(orbuf), .ofull(ofull),
    .ostart(ostart), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  // Outputs only change on edges where the DUT was enabled or reset.
  always @(posedge iclk) r_edge_live <= iclkena | ireset;

  // Monitor: compare each presented write against the scoreboard.
  always @(negedge iclk) begin
    if (r_edge_live) begin
      if (owrite) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL wr_unexpected: got buf=%0d addr=%0d dat=%h start=%0d err=%0d, expected no write",
                   owbuf, owaddr, owdat, ostart, oerr);
        end else begin
          wr_t e;
          wr_t a;
          e = exp_q.pop_front();
          a = '{wbuf: owbuf, addr: owaddr, dat: owdat, start: ostart, err: oerr};
          if (a !== e) begin
            miscompares++;
            $display("FAIL wr: got buf=%0d addr=%0d dat=%h start=%0d err=%0d, expected buf=%0d addr=%0d dat=%h start=%0d err=%0d",
                     a.wbuf, a.addr, a.dat, a.start, a.err, e.wbuf, e.addr, e.dat, e.start, e.err);
          end
        end
      end else if (ostart || oerr) begin
        vectors++;
        miscompares++;
        $display("FAIL pulse_without_write: got start=%0d err=%0d, expected 0 0", ostart, oerr);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic idle();
    ival = 1'b0; isop = 1'b0; ieop = 1'b0;
  endtask

  // Offer one word and wait (bounded) until it is accepted.
  task automatic send(input bit sop, input bit eop, input logic [7:0] dat,
                      input logic [7:0] len, input bit ew, input bit ebuf,
                      input logic [7:0] eaddr, input bit es, input bit ee);
    int budget;
    ival = 1'b1; isop = sop; ieop = eop; idat = dat; ilen_m1 = len;
    budget = 50;
    while (!ordy && budget > 0) begin
      tick();
      budget--;
    end
    if (!ordy) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got ordy=0 for word %h, expected acceptance", dat);
    end else begin
      if (ew) exp_q.push_back('{wbuf: ebuf, addr: eaddr, dat: dat, start: es, err: ee});
      tick();
    end
  endtask

  task automatic rdone();
    irdone = 1'b1;
    tick();
    irdone = 1'b0;
  endtask

  initial begin
    // reset
    ireset = 1'b1;
    repeat (3) tick();
    ireset = 1'b0;
    chk("reset_ordy", {7'd0, ordy}, 8'd1);
    chk("reset_ofull", {7'd0, ofull}, 8'd0);
    chk("reset_orbuf", {7'd0, orbuf}, 8'd0);
    chk("reset_owrite", {7'd0, owrite}, 8'd0);

    // block A: 4 words into buf 0, ieop on the last word
    send(1, 0, 8'h10, 8'd3, 1, 0, 8'd0, 0, 0);
    send(0, 0, 8'h11, 8'd3, 1, 0, 8'd1, 0, 0);
    send(0, 0, 8'h12, 8'd3, 1, 0, 8'd2, 0, 0);
    send(0, 1, 8'h13, 8'd3, 1, 0, 8'd3, 1, 0);
    idle();
    chk("A_ofull", {7'd0, ofull}, 8'd1);
    chk("A_orbuf", {7'd0, orbuf}, 8'd0);
    chk("A_ordy", {7'd0, ordy}, 8'd1);

    // block B: buf 1, then both buffers owned by the engine
    send(1, 0, 8'h20, 8'd3, 1, 1, 8'd0, 0, 0);
    send(0, 0, 8'h21, 8'd3, 1, 1, 8'd1, 0, 0);
    send(0, 0, 8'h22, 8'd3, 1, 1, 8'd2, 0, 0);
    send(0, 1, 8'h23, 8'd3, 1, 1, 8'd3, 1, 0);
    idle();
    chk("B_ordy", {7'd0, ordy}, 8'd0);

    // third block isop is held off until the engine releases a buffer
    ival = 1'b1; isop = 1'b1; ieop = 1'b0; idat = 8'h30; ilen_m1 = 8'd3;
    repeat (3) tick();
    chk("held_ordy", {7'd0, ordy}, 8'd0);
    rdone();
    chk("rel_ordy", {7'd0, ordy}, 8'd1);
    chk("rel_orbuf", {7'd0, orbuf}, 8'd1);
    chk("rel_ofull", {7'd0, ofull}, 8'd1);
    send(1, 0, 8'h30, 8'd3, 1, 0, 8'd0, 0, 0);
    send(0, 0, 8'h31, 8'd3, 1, 0, 8'd1, 0, 0);
    send(0, 0, 8'h32, 8'd3, 1, 0, 8'd2, 0, 0);
    send(0, 1, 8'h33, 8'd3, 1, 0, 8'd3, 1, 0);
    idle();
    rdone();
    rdone();
    chk("drain_ofull", {7'd0, ofull}, 8'd0);
    chk("drain_orbuf", {7'd0, orbuf}, 8'd1);

    // early ieop: len 8, ieop on word 2 -> error with the start pulse
    send(1, 0, 8'h40, 8'd7, 1, 1, 8'd0, 0, 0);
    send(0, 0, 8'h41, 8'd7, 1, 1, 8'd1, 0, 0);
    send(0, 1, 8'h42, 8'd7, 1, 1, 8'd2, 1, 1);
    idle();
    chk("D_ofull", {7'd0, ofull}, 8'd1);
    chk("D_orbuf", {7'd0, orbuf}, 8'd1);

    // completion coincident with irdone while one buffer is filled
    send(1, 0, 8'h50, 8'd1, 1, 0, 8'd0, 0, 0);
    irdone = 1'b1;
    send(0, 1, 8'h51, 8'd1, 1, 0, 8'd1, 1, 0);
    irdone = 1'b0;
    idle();
    chk("E_ofull", {7'd0, ofull}, 8'd1);
    chk("E_ordy", {7'd0, ordy}, 8'd1);
    chk("E_orbuf", {7'd0, orbuf}, 8'd0);

    // stray words, then an 8-word block restarted by isop at word 5
    send(0, 0, 8'h60, 8'd0, 0, 0, 8'd0, 0, 0);
    send(0, 0, 8'h61, 8'd0, 0, 0, 8'd0, 0, 0);
    send(1, 0, 8'h70, 8'd7, 1, 1, 8'd0, 0, 0);
    for (int i = 1; i < 5; i++) send(0, 0, 8'h70 + 8'(i), 8'd7, 1, 1, 8'(i), 0, 0);
    send(1, 0, 8'h78, 8'd7, 1, 1, 8'd0, 0, 0);
    for (int i = 1; i < 8; i++) send(0, 0, 8'h78 + 8'(i), 8'd7, 1, 1, 8'(i), (i == 7), 0);
    idle();
    chk("F_ordy", {7'd0, ordy}, 8'd0);
    rdone();
    chk("F_rel_ordy", {7'd0, ordy}, 8'd1);
    chk("F_rel_orbuf", {7'd0, orbuf}, 8'd1);
    send(0, 1, 8'h62, 8'd0, 0, 0, 8'd0, 0, 0);
    idle();

    // reset mid-block while the clock enable is low
    send(1, 0, 8'h80, 8'd3, 1, 0, 8'd0, 0, 0);
    send(0, 0, 8'h81, 8'd3, 1, 0, 8'd1, 0, 0);
    idle();
    iclkena = 1'b0;
    ireset = 1'b1;
    tick();
    ireset = 1'b0;
    iclkena = 1'b1;
    chk("rst2_ordy", {7'd0, ordy}, 8'd1);
    chk("rst2_ofull", {7'd0, ofull}, 8'd0);
    chk("rst2_orbuf", {7'd0, orbuf}, 8'd0);
    chk("rst2_owrite", {7'd0, owrite}, 8'd0);
    rdone();
    chk("ign_ofull", {7'd0, ofull}, 8'd0);
    chk("ign_orbuf", {7'd0, orbuf}, 8'd0);
    chk("ign_ordy", {7'd0, ordy}, 8'd1);

    // single-word blocks: matching length (no error) and mismatched length
    send(1, 1, 8'h90, 8'd0, 1, 0, 8'd0, 1, 0);
    send(1, 1, 8'h91, 8'd2, 1, 1, 8'd0, 1, 1);
    idle();
    chk("G_ordy", {7'd0, ordy}, 8'd0);

    repeat (3) tick();
    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
